// File: rtl/exe_stage_if.sv
// Bundles the ID/EXE control and operand inputs of the execute stage together
// with its branch and EXE/MEM outputs. The master side belongs to the decode
// stage (or a bench); the slave side belongs to exe_stage.
interface exe_stage_if;
  logic        freeze;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        b_in;
  logic        s_in;
  logic [3:0]  exe_cmd;
  logic        imm;
  logic [31:0] pc;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;

  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_result;
  logic [31:0] st_val;
  logic [3:0]  dest;

  modport master (
    output freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd, imm,
           pc, val_rn, val_rm, shift_operand, signed_imm_24, dest_in,
    input  branch_taken, branch_addr, status, wb_en, mem_r_en, mem_w_en,
           alu_result, st_val, dest
  );

  modport slave (
    input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd, imm,
           pc, val_rn, val_rm, shift_operand, signed_imm_24, dest_in,
    output branch_taken, branch_addr, status, wb_en, mem_r_en, mem_w_en,
           alu_result, st_val, dest
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: operand-2 generation (immediate rotate / register shift /
// memory offset), ALU with NZCV flags, status register, branch target adder
// and the EXE/MEM pipeline register. Status bit order is {N,Z,C,V}.
module exe_stage (
  input logic         clk,
  input logic         rst,
  exe_stage_if.slave  bus
);

  // Rotate right by 0..31; a rotate of 0 returns the input unchanged because
  // a left shift by the full width yields zero.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    ror32 = (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  logic        mem_op_s;
  logic [3:0]  alu_cmd_s;
  logic [4:0]  sh_amt_s;
  logic [31:0] val2_s;
  logic [31:0] add_b_s;
  logic        add_c_s;
  logic        arith_s;
  logic        valid_s;
  logic [31:0] logic_res_s;
  logic [32:0] sum_s;
  logic [31:0] alu_res_s;
  logic        cin_s;

  logic [3:0]  status_q, status_d;
  logic        wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [31:0] alu_result_q, st_val_q;
  logic [3:0]  dest_q;

  assign mem_op_s  = bus.mem_r_en_in | bus.mem_w_en_in;
  // Loads and stores always compute base + offset.
  assign alu_cmd_s = mem_op_s ? 4'b0010 : bus.exe_cmd;
  assign sh_amt_s  = bus.shift_operand[11:7];
  assign cin_s     = status_q[1];

  // Second operand: memory offset, rotated immediate, or shifted Rm.
  always_comb begin
    val2_s = bus.val_rm;
    if (mem_op_s) begin
      val2_s = {20'd0, bus.shift_operand};
    end else if (bus.imm) begin
      val2_s = ror32({24'd0, bus.shift_operand[7:0]}, {bus.shift_operand[11:8], 1'b0});
    end else begin
      case (bus.shift_operand[6:5])
        2'b00:   val2_s = bus.val_rm << sh_amt_s;
        2'b01:   val2_s = bus.val_rm >> sh_amt_s;
        2'b10:   val2_s = 32'($signed(bus.val_rm) >>> sh_amt_s);
        2'b11:   val2_s = ror32(bus.val_rm, sh_amt_s);
        default: val2_s = bus.val_rm;
      endcase
    end
  end

  // ALU command decode: subtraction is done as rn + ~val2 + carry so the
  // adder carry-out is directly the NOT-borrow flag.
  always_comb begin
    add_b_s     = val2_s;
    add_c_s     = 1'b0;
    arith_s     = 1'b0;
    valid_s     = 1'b1;
    logic_res_s = 32'd0;
    case (alu_cmd_s)
      4'b0001: logic_res_s = val2_s;
      4'b1001: logic_res_s = ~val2_s;
      4'b0010: arith_s = 1'b1;
      4'b0011: begin arith_s = 1'b1; add_c_s = cin_s; end
      4'b0100: begin arith_s = 1'b1; add_b_s = ~val2_s; add_c_s = 1'b1; end
      4'b0101: begin arith_s = 1'b1; add_b_s = ~val2_s; add_c_s = cin_s; end
      4'b0110: logic_res_s = bus.val_rn & val2_s;
      4'b0111: logic_res_s = bus.val_rn | val2_s;
      4'b1000: logic_res_s = bus.val_rn ^ val2_s;
      default: valid_s = 1'b0;
    endcase
  end

  assign sum_s = {1'b0, bus.val_rn} + {1'b0, add_b_s} + {32'd0, add_c_s};

  // Result select and next flags; undefined commands produce 0 and keep flags.
  always_comb begin
    alu_res_s = 32'd0;
    status_d  = status_q;
    if (!valid_s) begin
      alu_res_s = 32'd0;
      status_d  = status_q;
    end else if (arith_s) begin
      alu_res_s   = sum_s[31:0];
      status_d[3] = sum_s[31];
      status_d[2] = (sum_s[31:0] == 32'd0);
      status_d[1] = sum_s[32];
      status_d[0] = (bus.val_rn[31] == add_b_s[31]) && (sum_s[31] != bus.val_rn[31]);
    end else begin
      alu_res_s   = logic_res_s;
      status_d[3] = logic_res_s[31];
      status_d[2] = (logic_res_s == 32'd0);
      status_d[1] = status_q[1];
      status_d[0] = status_q[0];
    end
  end

  // Status register: updated only by flag-setting, non-branch, unfrozen ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 4'd0;
    end else if (!bus.freeze && bus.s_in && !bus.b_in) begin
      status_q <= status_d;
    end else begin
      status_q <= status_q;
    end
  end

  // EXE/MEM pipeline register, held while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      alu_result_q <= 32'd0;
      st_val_q     <= 32'd0;
      dest_q       <= 4'd0;
    end else if (!bus.freeze) begin
      wb_en_q      <= bus.wb_en_in;
      mem_r_en_q   <= bus.mem_r_en_in;
      mem_w_en_q   <= bus.mem_w_en_in;
      alu_result_q <= alu_res_s;
      st_val_q     <= bus.val_rm;
      dest_q       <= bus.dest_in;
    end
  end

  assign bus.branch_taken = bus.b_in;
  assign bus.branch_addr  = bus.pc + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};
  assign bus.status       = status_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.mem_r_en     = mem_r_en_q;
  assign bus.mem_w_en     = mem_w_en_q;
  assign bus.alu_result   = alu_result_q;
  assign bus.st_val       = st_val_q;
  assign bus.dest         = dest_q;

endmodule
